pipeline_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RISC-V pipeline, replacing the purely combinational hazard logic. It merges three stall and flush sources into per-stage StallX/FlushX controls: load-use hazards, taken branches, and a multi-cycle data-memory access sequencer with a req/gnt/rvalid handshake in MEM. It also detects hung memory accesses and counts memory stall cycles.

---
 rtl/pipeline_ctrl_pkg.sv | 17 +
 rtl/dmem_access_fsm.sv | 80 ++++++++
 rtl/pipeline_ctrl.sv | 87 ++++++++
 tb/tb_pipeline_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
//   mem_state_e            : data-memory access sequencer states
//   TIMEOUT_CYCLES_DEFAULT : default REQ+WAIT cycle budget per access
//   CNT_W_DEFAULT          : default width of the memory-stall counter
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ERR
  } mem_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;
  localparam int unsigned CNT_W_DEFAULT          = 32;

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer for the MEM stage.
//   clk, reset     : clock, asynchronous active-high reset
//   mem_access_m   : MEM instruction is a load or store
//   dmem_gnt       : memory accepted the request
//   dmem_rvalid    : access complete
//   dmem_req       : request, held until granted
//   mem_stall      : MEM instruction must be held this cycle
//   bus_error      : one-cycle pulse when an access is abandoned
module dmem_access_fsm
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_access_m,
  input  logic dmem_gnt,
  input  logic dmem_rvalid,
  output logic dmem_req,
  output logic mem_stall,
  output logic bus_error
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  mem_state_e      state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            done;
  logic            timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Completion takes priority over an expiring timeout in the same cycle.
  always_comb begin
    done     = (state_q == WAIT) && dmem_rvalid;
    timeout  = (state_q inside {REQ, WAIT}) && !done && (to_cnt_q == TO_LAST);
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    unique case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (mem_access_m) state_d = dmem_gnt ? WAIT : REQ;
      end
      REQ: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (timeout)       state_d = ERR;
        else if (dmem_gnt) state_d = WAIT;
      end
      WAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (done)         state_d = IDLE;
        else if (timeout) state_d = ERR;
      end
      ERR: begin
        to_cnt_d = '0;
        state_d  = IDLE;
      end
      default: begin
        to_cnt_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_comb begin
    dmem_req  = ((state_q == IDLE) && mem_access_m) || (state_q == REQ);
    mem_stall = mem_access_m && !done && (state_q != ERR);
    bus_error = (state_q == ERR);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
//   clk, reset             : clock, asynchronous active-high reset
//   Rs1D, Rs2D, RdE        : Decode sources / EX destination
//   ResultSrcE0            : EX instruction is a load
//   PCSrcE                 : branch/jump taken in EX
//   MemAccessM             : MEM instruction accesses data memory
//   dmem_req/gnt/rvalid    : data-memory handshake
//   StallF/D/E/M           : hold stage register
//   FlushD/E/W             : bubble stage register
//   bus_error              : access timed out (one-cycle pulse)
//   mem_stall_cnt          : saturating count of memory-stall cycles
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned CNT_W          = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  output logic             dmem_req,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             bus_error,
  output logic [CNT_W-1:0] mem_stall_cnt
);

  logic             mem_stall;
  logic             lw_stall;
  logic             lw_eff;
  logic [CNT_W-1:0] mem_stall_cnt_q, mem_stall_cnt_d;

  dmem_access_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dmem_access_fsm (
    .clk         (clk),
    .reset       (reset),
    .mem_access_m(MemAccessM),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_req    (dmem_req),
    .mem_stall   (mem_stall),
    .bus_error   (bus_error)
  );

  // A taken branch flushes Decode anyway, so the load-use stall is dropped.
  always_comb begin
    lw_stall = ResultSrcE0 && ((Rs1D == RdE) || (Rs2D == RdE)) && (RdE != '0);
    lw_eff   = lw_stall && !PCSrcE;
  end

  // Memory stall freezes the whole front of the pipe and defers any flush.
  always_comb begin
    StallF = mem_stall || lw_eff;
    StallD = mem_stall || lw_eff;
    StallE = mem_stall;
    StallM = mem_stall;
    FlushW = mem_stall;
    FlushE = !mem_stall && (lw_eff || PCSrcE);
    FlushD = !mem_stall && PCSrcE;
  end

  always_comb begin
    mem_stall_cnt_d = mem_stall_cnt_q;
    if (mem_stall && (mem_stall_cnt_q != '1)) mem_stall_cnt_d = mem_stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_stall_cnt_q <= '0;
    else       mem_stall_cnt_q <= mem_stall_cnt_d;
  end

  assign mem_stall_cnt = mem_stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int T       = 8;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int NEVER   = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    Rs1D, Rs2D, RdE;
  logic          ResultSrcE0, PCSrcE, MemAccessM;
  logic          dmem_req, dmem_gnt, dmem_rvalid;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW, bus_error;
  logic [CW-1:0] mem_stall_cnt;

  int total  = 0;
  int passed = 0;
  int model_cnt = 0;

  pipeline_ctrl #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .RdE          (RdE),
    .ResultSrcE0  (ResultSrcE0),
    .PCSrcE       (PCSrcE),
    .MemAccessM   (MemAccessM),
    .dmem_req     (dmem_req),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .bus_error    (bus_error),
    .mem_stall_cnt(mem_stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: check outputs against the model on the falling edge, then
  // advance past the next rising edge. ms/req/berr come from the access
  // schedule; stalls/flushes follow the priority rules.
  task automatic tick(input string tag, input bit ms, input bit req, input bit berr);
    bit         match;
    bit         s_fd, s_em, f_d, f_e, f_w;
    logic [8:0] exp_v, obs_v;
    @(negedge clk);
    if (reset) model_cnt = 0;
    match = ResultSrcE0 && (RdE != 0) && ((Rs1D == RdE) || (Rs2D == RdE));
    s_fd = 0; s_em = 0; f_d = 0; f_e = 0; f_w = 0;
    if (ms) begin
      s_fd = 1; s_em = 1; f_w = 1;
    end else if (PCSrcE) begin
      f_d = 1; f_e = 1;
    end else if (match) begin
      s_fd = 1; f_e = 1;
    end
    exp_v = {req, s_fd, s_fd, s_em, s_em, f_d, f_e, f_w, berr};
    obs_v = {dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, bus_error};
    chk({tag, ".ctl"}, 32'(obs_v), 32'(exp_v));
    chk({tag, ".cnt"}, 32'(mem_stall_cnt), 32'(model_cnt));
    if (!reset && ms && model_cnt < CNT_MAX) model_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pipe();
    Rs1D        = 5'($urandom_range(0, 3));
    Rs2D        = 5'($urandom_range(0, 3));
    RdE         = 5'($urandom_range(0, 3));
    ResultSrcE0 = 1'($urandom_range(0, 1));
    PCSrcE      = ($urandom_range(0, 3) == 0);
  endtask

  task automatic clear_pipe();
    Rs1D = '0; Rs2D = '0; RdE = '0; ResultSrcE0 = 0; PCSrcE = 0;
  endtask

  // Access with grant at cycle g and response r cycles later. Stall lasts
  // g+r cycles if that fits the budget; otherwise T+1 cycles then ERR.
  task automatic do_access(input string tag, input int g, input int r, input bit rnd);
    bit to;
    int last;
    int req_last;
    to       = (g + r > T);
    last     = to ? T + 1 : g + r;
    req_last = (g < T) ? g : T;
    for (int i = 0; i <= last; i++) begin
      MemAccessM  = 1;
      dmem_gnt    = (i == g) && (i <= T);
      dmem_rvalid = (i == g + r) && (i <= T);
      if (rnd) rand_pipe();
      if (to) tick(tag, i <= T, i <= req_last, i == T + 1);
      else    tick(tag, i < g + r, i <= g, 0);
    end
    MemAccessM  = 0;
    dmem_gnt    = 0;
    dmem_rvalid = 0;
  endtask

  initial begin
    reset = 1; MemAccessM = 0; dmem_gnt = 0; dmem_rvalid = 0;
    clear_pipe();
    tick("reset", 0, 0, 0);
    tick("reset", 0, 0, 0);
    reset = 0;
    tick("idle", 0, 0, 0);

    // load-use
    ResultSrcE0 = 1; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd1;
    tick("lw_rs1", 0, 0, 0);
    Rs1D = 5'd2; Rs2D = 5'd5;
    tick("lw_rs2", 0, 0, 0);
    RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    tick("lw_x0", 0, 0, 0);
    // branch overrides load-use
    RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1;
    tick("br_lw", 0, 0, 0);
    clear_pipe();

    // minimum access
    do_access("min", 0, 1, 0);
    tick("min_after", 0, 0, 0);

    // delayed grant, branch held under stall
    PCSrcE = 1;
    do_access("g3r2", 3, 2, 0);
    clear_pipe();
    tick("g3r2_after", 0, 0, 0);

    // completion exactly at the last budget cycle wins over timeout
    do_access("edge_ok", 0, T, 0);
    // one cycle later it times out in WAIT
    do_access("edge_to", 0, T + 1, 0);

    // grant never arrives
    do_access("timeout", NEVER, 1, 1);
    clear_pipe();
    dmem_rvalid = 1;
    tick("stray", 0, 0, 0);
    dmem_rvalid = 0;
    tick("stray_after", 0, 0, 0);
    do_access("post_stray", 0, 1, 0);

    // randomized traffic, back-to-back and with gaps
    for (int n = 0; n < 40; n++) begin
      do_access("rnd", $urandom_range(0, 4), $urandom_range(1, 5), 1);
      if ($urandom_range(0, 2) == 0) begin
        rand_pipe();
        tick("rnd_gap", 0, 0, 0);
      end
    end

    // reset in WAIT
    clear_pipe();
    MemAccessM = 1; dmem_gnt = 1;
    tick("rstw_0", 1, 1, 0);
    dmem_gnt = 0;
    tick("rstw_1", 1, 0, 0);
    reset = 1; MemAccessM = 0;
    tick("rstw_rst", 0, 0, 0);
    reset = 0;
    tick("rstw_idle", 0, 0, 0);
    do_access("rstw_post", 1, 1, 0);

    // saturation: 8 timeouts give 72 stall cycles, counter stops at 63
    reset = 1;
    tick("sat_rst", 0, 0, 0);
    reset = 0;
    for (int n = 0; n < 8; n++) do_access("sat", NEVER, 1, 1);
    clear_pipe();
    tick("sat_end", 0, 0, 0);
    chk("sat_max", 32'(mem_stall_cnt), 32'(CNT_MAX));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
